// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Initiator-side sequencer for the registered ALU. It accepts one command at
// a time over a valid/ready channel and drives the ALU operand/opcode
// registers. It waits out the ALU pipeline latency, captures the result, and
// returns it over a valid/ready response channel.
// Optional feature macro: ALU_SEQ_CHECK_EN. When it is defined, the sequencer
// computes the expected result at accept time and flags rsp_err on mismatch.
// When it is undefined, no checker is built and rsp_err is tied low.
`timescale 1ns/1ps
module alu_cmd_sequencer #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    input  logic [1:0]           cmd_op,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [1:0]           alu_opcode,
    input  logic [2*WIDTH-1:0]   alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_data,
    output logic [1:0]           rsp_op,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [7:0]           done_cnt
);

    // The counter must be able to reach LATENCY; keep at least one bit.
    localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     alu_a_q, alu_a_d;
    logic [WIDTH-1:0]     alu_b_q, alu_b_d;
    logic [1:0]           alu_op_q, alu_op_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]           rsp_op_q, rsp_op_d;
    logic [7:0]           done_cnt_q, done_cnt_d;

    logic                 accept;
    logic                 capture;
    logic                 handshake;

    // Handshake and capture qualifiers shared by the datapath and the checker.
    always_comb begin
        accept    = (state_q == IDLE) && cmd_valid && !rst;
        capture   = (state_q == WAIT) && (cnt_q == CW'(LATENCY));
        handshake = (state_q == RESP) && rsp_ready;
    end

    // Next-state and register update logic; everything holds by default.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_op_d    = rsp_op_q;
        done_cnt_d  = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_a_d  = cmd_a;
                    alu_b_d  = cmd_b;
                    alu_op_d = cmd_op;
                    cnt_d    = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (capture) begin
                    rsp_data_d  = alu_result;
                    rsp_op_d    = alu_op_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (handshake) begin
                    rsp_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_op_q    <= 2'b00;
            done_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_op_q    <= rsp_op_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    logic [2*WIDTH-1:0] exp_q, exp_d;
    logic               rsp_err_q, rsp_err_d;

    // Reference result with the ALU's zero-extension rules applied.
    function automatic logic [2*WIDTH-1:0] expected_result(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       op
    );
        logic [2*WIDTH-1:0] a_ext;
        logic [2*WIDTH-1:0] b_ext;
        a_ext = {{WIDTH{1'b0}}, a};
        b_ext = {{WIDTH{1'b0}}, b};
        case (op)
            2'b00:   expected_result = a_ext + b_ext;
            2'b01:   expected_result = a_ext * b_ext;
            2'b10:   expected_result = a_ext | b_ext;
            default: expected_result = a_ext & b_ext;
        endcase
    endfunction

    // Latch the expectation at accept and compare it with the ALU at capture.
    always_comb begin
        exp_d     = exp_q;
        rsp_err_d = rsp_err_q;
        if (accept) begin
            exp_d = expected_result(cmd_a, cmd_b, cmd_op);
        end
        if (capture) begin
            rsp_err_d = (alu_result != exp_q);
        end else if (handshake) begin
            rsp_err_d = 1'b0;
        end
    end

    // Checker registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            exp_q     <= exp_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign busy       = (state_q != IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_op     = rsp_op_q;
    assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer with a two-stage registered ALU
// model. The ALU model has a fault switch that returns 0 for add 3+4.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [1:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_opcode;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_op;
    logic       rsp_err;
    logic       busy;
    logic [7:0] done_cnt;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_done = 8'd0;
    logic       alu_fault = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(4), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    // Registered 4-bit ALU: input registers, then a registered result.
    logic [3:0] ma_q   = 4'd0;
    logic [3:0] mb_q   = 4'd0;
    logic [1:0] mop_q  = 2'd0;
    logic [7:0] mres_q = 8'd0;
    always @(posedge clk) begin
        ma_q  <= alu_a;
        mb_q  <= alu_b;
        mop_q <= alu_opcode;
        if (alu_fault && mop_q == 2'b00 && ma_q == 4'd3 && mb_q == 4'd4)
            mres_q <= 8'd0;
        else begin
            case (mop_q)
                2'b00:   mres_q <= {4'd0, ma_q} + {4'd0, mb_q};
                2'b01:   mres_q <= {4'd0, ma_q} * {4'd0, mb_q};
                2'b10:   mres_q <= {4'd0, ma_q | mb_q};
                default: mres_q <= {4'd0, ma_q & mb_q};
            endcase
        end
    end
    assign alu_result = mres_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One full command/response transaction; stall = cycles rsp_ready stays low
    // after rsp_valid rises (a stray cmd_valid pulse is injected during the stall).
    task automatic do_txn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          input logic [7:0] exp_data, input logic exp_err, input int stall);
        int n;
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a     = ~a;
        cmd_b     = ~b;
        check("alu_a", 32'(alu_a), 32'(a));
        check("alu_b", 32'(alu_b), 32'(b));
        check("alu_opcode", 32'(alu_opcode), 32'(op));
        check("busy_wait", 32'(busy), 32'd1);
        check("cmd_ready_wait", 32'(cmd_ready), 32'd0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd3);
        if (n >= 16) return;
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        check("rsp_op", 32'(rsp_op), 32'(op));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("done_before", 32'(done_cnt), 32'(exp_done));
        for (int s = 0; s < stall; s++) begin
            if (s == 1) begin
                cmd_valid = 1'b1;
                cmd_a     = a ^ 4'hF;
                cmd_b     = b ^ 4'h5;
                cmd_op    = op ^ 2'b01;
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_data), 32'(exp_data));
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_alu_a", 32'(alu_a), 32'(a));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_done  = exp_done + 8'd1;
        check("hs_valid", 32'(rsp_valid), 32'd0);
        check("hs_busy", 32'(busy), 32'd0);
        check("hs_cmd_ready", 32'(cmd_ready), 32'd1);
        check("hs_done", 32'(done_cnt), 32'(exp_done));
        check("hs_err_clr", 32'(rsp_err), 32'd0);
        $display("[TB] txn a=%0d b=%0d op=%0d -> data=%0d err=%0d done=%0d",
                 a, b, op, exp_data, exp_err, exp_done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = 4'd0;
        cmd_b     = 4'd0;
        cmd_op    = 2'b00;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done_cnt), 32'd0);
        rst = 1'b0;

        // Main function: add, mul, or, and.
        do_txn(4'd9,     4'd8,     2'b00, 8'd17,  1'b0, 0);
        do_txn(4'd15,    4'd15,    2'b01, 8'd225, 1'b0, 0);
        do_txn(4'b1010,  4'b0101,  2'b10, 8'h0F,  1'b0, 0);
        do_txn(4'b1100,  4'b1010,  2'b11, 8'h08,  1'b0, 0);
        // Add with carry out of WIDTH bits, under 5 cycles of backpressure.
        do_txn(4'd15,    4'd1,     2'b00, 8'd16,  1'b0, 5);

        // Reset asserted while in WAIT.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a     = 4'd6;
        cmd_b     = 4'd7;
        cmd_op    = 2'b01;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_alu_a", 32'(alu_a), 32'd0);
        check("mid_rst_alu_b", 32'(alu_b), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_done", 32'(done_cnt), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        exp_done = 8'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("post_rst_done", 32'(done_cnt), 32'd0);

        // 256 commands: a + ~a is always 15; done_cnt wraps to 0 at the end.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            do_txn(iv[3:0], ~iv[3:0], 2'b00, 8'd15, 1'b0, 0);
        end
        check("done_wrap", 32'(done_cnt), 32'd0);

        // Faulty ALU on add 3+4, then the correct ALU.
        alu_fault = 1'b1;
`ifdef ALU_SEQ_CHECK_EN
        do_txn(4'd3, 4'd4, 2'b00, 8'd0, 1'b1, 0);
`else
        do_txn(4'd3, 4'd4, 2'b00, 8'd0, 1'b0, 0);
`endif
        alu_fault = 1'b0;
        do_txn(4'd3, 4'd4, 2'b00, 8'd7, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
